mult_share_ctrl: RTL
====================

// Module: mult_share_ctrl
// PURPOSE
//  Round-robin controller sharing one external 8-cycle shift-add multiplier among NREQ requesters.
//  Arbitrates, latches the winner's operands, pulses the multiplier start and waits for done.
//  Returns the product to the winner with a one-cycle response strobe.
//  A watchdog flags a multiplier that never asserts done.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  W        8   operand/product width; must match multiplier
//  TIMEOUT  12  max WAIT cycles before error (nominal need is 9; must be >=10)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active high
//  req           in   NREQ    per-requester request level
//  req_a         in   NREQ*W  operand A, slice i = [i*W +: W]
//  req_b         in   NREQ*W  operand B, slice i
//  gnt           out  NREQ    one-hot grant, held from grant through RESP
//  rsp_valid     out  NREQ    one-hot, one-cycle response strobe
//  rsp_product   out  W       result; valid when any rsp_valid bit is set
//  rsp_err       out  1       qualifies rsp_valid: watchdog expired
//  busy          out  1       high in any state other than IDLE
//  mult_start    out  1       one-cycle start pulse to multiplier
//  mult_a        out  W       registered operand A to multiplier
//  mult_b        out  W       registered operand B to multiplier
//  mult_done     in   1       multiplier done level
//  mult_product  in   W       multiplier product, valid while done=1
// BEHAVIOUR
//  Reset (async):
//   - State = IDLE; rr pointer = 0.
//   - All outputs 0, including mult_a, mult_b and rsp_product.
//  FSM states: IDLE -> START -> WAIT -> RESP -> IDLE. All outputs are registered.
//  IDLE:
//   - If req != 0, grant the first set bit searching ptr, ptr+1, ... (mod NREQ).
//   - Latch req_a/req_b of the winner into mult_a/mult_b; set gnt; go to START.
//   - Set ptr = winner+1 (mod NREQ).
//   - If req == 0, stay in IDLE.
//  START:
//   - mult_start = 1 for exactly this cycle; clear wait_cnt; go to WAIT.
//   - mult_done is ignored here, because it is stale from the previous operation.
//  WAIT:
//   - wait_cnt increments each cycle.
//   - mult_done = 1: capture mult_product into rsp_product; rsp_err = 0; go to RESP.
//   - mult_done = 0 and wait_cnt == TIMEOUT: rsp_product = 0; rsp_err = 1; go to RESP.
//   - mult_done has priority when both occur in the same cycle.
//  RESP:
//   - rsp_valid[winner] = 1 for one cycle.
//   - gnt is cleared at the next edge; go to IDLE.
//   - rsp_product and rsp_err hold until the next capture.
//  Latency:
//   - Grant edge E0; mult_start high in cycle E0..E1.
//   - Multiplier done is visible after E9, captured at E10.
//   - rsp_valid is high in cycle E10..E11.
//   - Next grant at the earliest at E12, so one op per 12 cycles.
//  Requester rules:
//   - Operands are sampled only at the grant edge; later changes are ignored.
//   - Dropping req after grant does not abort; the response is still delivered.
//   - A req still high in the IDLE cycle after RESP is re-arbitrated, so it may win again if alone.
//  Simultaneous events:
//   - New requests arriving during START/WAIT/RESP wait for IDLE.
//   - There is no preemption.
//  Reset mid-operation:
//   - FSM aborts to IDLE; no rsp_valid is produced.
//   - The multiplier is not reset; its done is ignored until after the next START.
//  Width: the product is W bits, truncated as the multiplier provides; no carry-out.
// TESTING
//  Single op: req=0001, a0=5, b0=7, model multiplier
//   -> gnt=0001 at E0; mult_start pulse at E0; rsp_valid=0001 in E10; rsp_product=35; rsp_err=0.
//  Round-robin: req=1111 held for 4 ops, from reset
//   -> grant order 0,1,2,3; next grant after that is 0.
//  Truncation: a=16, b=20
//   -> rsp_product=320 mod 256=64; a=255, b=1 -> 255.
//  Watchdog: mult_done tied 0, req=0100
//   -> rsp_valid=0100, rsp_err=1, rsp_product=0, 13 cycles after the START cycle; FSM back in IDLE.
//  Reset in WAIT: assert rst at E5
//   -> all outputs 0 immediately; no rsp_valid.
//   -> A new req then completes normally with correct product.
//  Operand change/drop: change a1 and drop req1 at E3
//   -> the response still uses the grant-time operands and arrives at E10.

Source files
------------

// File: rtl/mult_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_ctrl_if
//  Description : Bundle of the requester-side and multiplier-side signals of
//                mult_share_ctrl.
//                  req/req_a/req_b     requester request level and operands
//                  gnt/rsp_*           grant, response strobe, product, error
//                  busy                controller not idle
//                  mult_*              link to the shared external multiplier
//                The slave modport is the controller; the master modport is
//                the environment (requesters plus multiplier).
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_product;
  logic              rsp_err;
  logic              busy;
  logic              mult_start;
  logic [W-1:0]      mult_a;
  logic [W-1:0]      mult_b;
  logic              mult_done;
  logic [W-1:0]      mult_product;

  modport slave (
    input  req, req_a, req_b, mult_done, mult_product,
    output gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b
  );

  modport master (
    output req, req_a, req_b, mult_done, mult_product,
    input  gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_ctrl
//  Description : Round-robin controller that shares one external multi-cycle
//                multiplier among NREQ requesters. Grants one requester,
//                latches its operands, pulses mult_start, waits for
//                mult_done (guarded by a watchdog) and returns the product
//                with a one-cycle rsp_valid strobe.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active high
//                bus  - mult_share_ctrl_if.slave (requests, grant, response,
//                       multiplier start/operands/done/product)
//  Revision    : 1.0  initial release
// ============================================================================
module mult_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 12
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mult_share_ctrl_if.slave  bus
);

  localparam int c_PTR_W = $clog2(NREQ);
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   r_win;
  logic [c_CNT_W-1:0]   r_wait_cnt;

  logic                 w_found;
  logic [c_PTR_W-1:0]   w_win;
  logic [c_PTR_W-1:0]   w_next_ptr;

  // Round-robin search starting at r_ptr. Walking the offsets downwards lets
  // the smallest offset with a request overwrite any larger one.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = c_PTR_W'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_next_ptr = (w_win == c_PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_win           <= '0;
      r_wait_cnt      <= '0;
      bus.gnt         <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_product <= '0;
      bus.rsp_err     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.mult_start  <= 1'b0;
      bus.mult_a      <= '0;
      bus.mult_b      <= '0;
    end else begin
      // Single-cycle strobes default low.
      bus.mult_start <= 1'b0;
      bus.rsp_valid  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win          <= w_win;
            r_ptr          <= w_next_ptr;
            bus.gnt        <= NREQ'(1) << w_win;
            bus.mult_a     <= bus.req_a[int'(w_win) * W +: W];
            bus.mult_b     <= bus.req_b[int'(w_win) * W +: W];
            // Raised here so the pulse occupies exactly the START cycle.
            bus.mult_start <= 1'b1;
            bus.busy       <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: begin
          // mult_done may still be high from the previous operation; it is
          // not looked at until the multiplier has seen this start pulse.
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mult_done) begin
            bus.rsp_product <= bus.mult_product;
            bus.rsp_err     <= 1'b0;
            bus.rsp_valid   <= NREQ'(1) << r_win;
            r_state         <= S_RESP;
          end else if (r_wait_cnt == c_CNT_W'(TIMEOUT)) begin
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_valid   <= NREQ'(1) << r_win;
            r_state         <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
